// File: rtl/fp8_output_packer_if.sv
// Byte-in / word-out stream bundle for the FP8 output packer.
interface fp8_output_packer_if #(
  parameter int unsigned LANES = 4
);
  logic               in_valid;
  logic               in_ready;
  logic [7:0]         in_fp8;
  logic               in_last;
  logic               out_valid;
  logic               out_ready;
  logic [8*LANES-1:0] out_data;
  logic [LANES-1:0]   out_keep;
  logic               out_last;

  // Environment side: produces bytes, consumes words.
  modport master (
    output in_valid, in_fp8, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_keep, out_last
  );

  // Packer side: consumes bytes, produces words.
  modport slave (
    input  in_valid, in_fp8, in_last, out_ready,
    output in_ready, out_valid, out_data, out_keep, out_last
  );
endinterface

// File: rtl/fp8_output_packer.sv
// Packs a stream of FP8 bytes into LANES-wide words, buffers completed words in a
// small FIFO and counts Inf/NaN encodings seen on accepted bytes.
module fp8_output_packer #(
  parameter int unsigned LANES      = 4,
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  fp8_output_packer_if.slave    bus,
  input  logic                  cnt_clr,
  output logic [CNT_W-1:0]      inf_cnt,
  output logic [CNT_W-1:0]      nan_cnt
);

  localparam int unsigned IDX_W  = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_FW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned DATA_W = 8 * LANES;

  typedef struct packed {
    logic              last;
    logic [LANES-1:0]  keep;
    logic [DATA_W-1:0] data;
  } word_t;

  // State
  logic [IDX_W-1:0]  lane_idx;
  logic [DATA_W-1:0] asm_data;
  word_t             mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_FW-1:0] count;
  logic              in_ready_q;
  logic              out_valid_q;
  word_t             out_word_q;
  logic [CNT_W-1:0]  inf_cnt_q;
  logic [CNT_W-1:0]  nan_cnt_q;

  // Next-state
  logic              accept;
  logic              pop;
  logic              commit;
  logic [DATA_W-1:0] asm_word;
  logic [LANES-1:0]  push_keep;
  word_t             push_word;
  word_t             mem_n [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_n;
  logic [PTR_W-1:0]  rd_ptr_n;
  logic [CNT_FW-1:0] count_n;
  logic              is_inf;
  logic              is_nan;

  // Handshakes, word assembly and FIFO next state; output word is the next FIFO head.
  always_comb begin
    accept    = bus.in_valid && in_ready_q;
    pop       = out_valid_q && bus.out_ready;
    asm_word  = asm_data;
    asm_word[{lane_idx, 3'b000} +: 8] = bus.in_fp8;
    commit    = accept && (bus.in_last || (lane_idx == IDX_W'(LANES - 1)));
    push_keep = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      push_keep[k] = (IDX_W'(k) <= lane_idx);
    end
    push_word.last = bus.in_last;
    push_word.keep = push_keep;
    push_word.data = asm_word;

    mem_n = mem;
    if (commit) begin
      mem_n[wr_ptr] = push_word;
    end
    wr_ptr_n = commit ? (wr_ptr + PTR_W'(1)) : wr_ptr;
    rd_ptr_n = pop    ? (rd_ptr + PTR_W'(1)) : rd_ptr;
    count_n  = count + CNT_FW'(commit) - CNT_FW'(pop);

    is_inf = (bus.in_fp8[6:3] == 4'hF) && (bus.in_fp8[2:0] == 3'b000);
    is_nan = (bus.in_fp8[6:3] == 4'hF) && (bus.in_fp8[2:0] != 3'b000);
  end

  // Assembly register and lane index; a committed word restarts at lane 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_idx <= '0;
      asm_data <= '0;
    end else if (commit) begin
      lane_idx <= '0;
      asm_data <= '0;
    end else if (accept) begin
      lane_idx <= lane_idx + IDX_W'(1);
      asm_data <= asm_word;
    end
  end

  // FIFO storage, pointers, flags and registered head word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_word_q  <= '0;
    end else begin
      mem         <= mem_n;
      wr_ptr      <= wr_ptr_n;
      rd_ptr      <= rd_ptr_n;
      count       <= count_n;
      in_ready_q  <= (count_n != CNT_FW'(FIFO_DEPTH));
      out_valid_q <= (count_n != '0);
      out_word_q  <= (count_n != '0) ? mem_n[rd_ptr_n] : '0;
    end
  end

  // Saturating Inf/NaN counters; clear wins over a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inf_cnt_q <= '0;
      nan_cnt_q <= '0;
    end else if (cnt_clr) begin
      inf_cnt_q <= '0;
      nan_cnt_q <= '0;
    end else begin
      if (accept && is_inf && (inf_cnt_q != '1)) begin
        inf_cnt_q <= inf_cnt_q + CNT_W'(1);
      end
      if (accept && is_nan && (nan_cnt_q != '1)) begin
        nan_cnt_q <= nan_cnt_q + CNT_W'(1);
      end
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_word_q.data;
  assign bus.out_keep  = out_word_q.keep;
  assign bus.out_last  = out_word_q.last;
  assign inf_cnt       = inf_cnt_q;
  assign nan_cnt       = nan_cnt_q;

endmodule
